// File: rtl/bram_rd_stream.sv
// bram_rd_stream: streams a range of words out of a BRAM with a registered
// read port onto a valid/ready stream.
//
// Ports
//   clk        rising-edge clock shared with the BRAM
//   rstn       synchronous active-low reset
//   start      one-cycle request to stream a range (ignored while busy)
//   base_addr  first word address, sampled with start
//   length     number of words 0..2**ADDRESS_WIDTH, sampled with start
//   busy       high from the cycle after an accepted start until done
//   done       one-cycle completion pulse
//   rd_addr    BRAM read address
//   bram_dout  BRAM read data, valid one cycle after rd_addr
//   m_data     stream data (FIFO head)
//   m_valid    stream data valid
//   m_ready    downstream ready
//   m_last     final beat marker, qualified by m_valid
module bram_rd_stream #(
   parameter int unsigned DATA_WIDTH    = 8,
   parameter int unsigned ADDRESS_WIDTH = 8
) (
   input  logic                     clk,
   input  logic                     rstn,
   input  logic                     start,
   input  logic [ADDRESS_WIDTH-1:0] base_addr,
   input  logic [ADDRESS_WIDTH:0]   length,
   output logic                     busy,
   output logic                     done,
   output logic [ADDRESS_WIDTH-1:0] rd_addr,
   input  logic [DATA_WIDTH-1:0]    bram_dout,
   output logic [DATA_WIDTH-1:0]    m_data,
   output logic                     m_valid,
   input  logic                     m_ready,
   output logic                     m_last
);

   localparam int unsigned DEPTH = 3;
   localparam int unsigned CNT_W = 2;
   localparam int unsigned SUM_W = 3;
   localparam int unsigned REM_W = ADDRESS_WIDTH + 1;

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      RUN   = 2'd1,
      DRAIN = 2'd2
   } state_t;

   state_t                   state, state_nxt;
   logic [ADDRESS_WIDTH-1:0] addr_q, addr_nxt;
   logic [REM_W-1:0]         rem_q, rem_nxt;
   logic                     pend_q, pend_nxt;
   logic                     pend_last_q, pend_last_nxt;
   logic                     busy_q, busy_nxt;
   logic                     done_q, done_nxt;

   logic [DATA_WIDTH-1:0]    fifo_data_q   [DEPTH];
   logic [DATA_WIDTH-1:0]    fifo_data_nxt [DEPTH];
   logic [DEPTH-1:0]         fifo_vld_q, fifo_vld_nxt;
   logic [DEPTH-1:0]         fifo_last_q, fifo_last_nxt;

   logic [CNT_W-1:0]         fifo_count;
   logic [CNT_W-1:0]         wr_idx;
   logic                     pop;
   logic                     issue;

   // Occupancy of the shift FIFO; valid bits are always packed toward entry 0.
   assign fifo_count = CNT_W'(fifo_vld_q[0]) + CNT_W'(fifo_vld_q[1]) + CNT_W'(fifo_vld_q[2]);
   assign pop        = fifo_vld_q[0] & m_ready;
   assign wr_idx     = fifo_count - CNT_W'(pop);

   // Issue only while the FIFO plus the read in flight leave room for one more word.
   assign issue = (state == RUN) &&
                  ((SUM_W'(fifo_count) + SUM_W'(pend_q)) < SUM_W'(DEPTH));

   // State register.
   always_ff @(posedge clk) begin
      if (!rstn) begin
         state <= IDLE;
      end else begin
         state <= state_nxt;
      end
   end

   // Next-state, read issue and status.
   always_comb begin
      state_nxt     = state;
      addr_nxt      = addr_q;
      rem_nxt       = rem_q;
      pend_nxt      = 1'b0;
      pend_last_nxt = 1'b0;
      busy_nxt      = busy_q;
      done_nxt      = 1'b0;

      case (state)
         IDLE: begin
            if (start) begin
               if (length != '0) begin
                  state_nxt = RUN;
                  addr_nxt  = base_addr;
                  rem_nxt   = length;
                  busy_nxt  = 1'b1;
               end else begin
                  done_nxt  = 1'b1;
               end
            end
         end

         RUN: begin
            if (issue) begin
               pend_nxt      = 1'b1;
               pend_last_nxt = (rem_q == REM_W'(1));
               addr_nxt      = addr_q + ADDRESS_WIDTH'(1);
               rem_nxt       = rem_q - REM_W'(1);
               if (rem_q == REM_W'(1)) begin
                  state_nxt = DRAIN;
               end
            end
         end

         DRAIN: begin
            // Completion is the handshake of the beat flagged last.
            if (pop && fifo_last_q[0]) begin
               state_nxt = IDLE;
               busy_nxt  = 1'b0;
               done_nxt  = 1'b1;
            end
         end

         default: begin
            state_nxt = IDLE;
         end
      endcase
   end

   // Shift FIFO: pop shifts toward the head, push lands in the first free slot.
   always_comb begin
      for (int i = 0; i < DEPTH - 1; i++) begin
         fifo_data_nxt[i] = pop ? fifo_data_q[i+1] : fifo_data_q[i];
         fifo_vld_nxt[i]  = pop ? fifo_vld_q[i+1]  : fifo_vld_q[i];
         fifo_last_nxt[i] = pop ? fifo_last_q[i+1] : fifo_last_q[i];
      end
      fifo_data_nxt[DEPTH-1] = pop ? '0   : fifo_data_q[DEPTH-1];
      fifo_vld_nxt[DEPTH-1]  = pop ? 1'b0 : fifo_vld_q[DEPTH-1];
      fifo_last_nxt[DEPTH-1] = pop ? 1'b0 : fifo_last_q[DEPTH-1];

      // BRAM data is only meaningful the cycle after an issued read.
      if (pend_q) begin
         for (int i = 0; i < DEPTH; i++) begin
            if (wr_idx == CNT_W'(i)) begin
               fifo_data_nxt[i] = bram_dout;
               fifo_vld_nxt[i]  = 1'b1;
               fifo_last_nxt[i] = pend_last_q;
            end
         end
      end
   end

   // Datapath registers.
   always_ff @(posedge clk) begin
      if (!rstn) begin
         addr_q      <= '0;
         rem_q       <= '0;
         pend_q      <= 1'b0;
         pend_last_q <= 1'b0;
         busy_q      <= 1'b0;
         done_q      <= 1'b0;
         fifo_vld_q  <= '0;
         fifo_last_q <= '0;
         for (int i = 0; i < DEPTH; i++) begin
            fifo_data_q[i] <= '0;
         end
      end else begin
         addr_q      <= addr_nxt;
         rem_q       <= rem_nxt;
         pend_q      <= pend_nxt;
         pend_last_q <= pend_last_nxt;
         busy_q      <= busy_nxt;
         done_q      <= done_nxt;
         fifo_vld_q  <= fifo_vld_nxt;
         fifo_last_q <= fifo_last_nxt;
         for (int i = 0; i < DEPTH; i++) begin
            fifo_data_q[i] <= fifo_data_nxt[i];
         end
      end
   end

   assign rd_addr = addr_q;
   assign busy    = busy_q;
   assign done    = done_q;
   assign m_data  = fifo_data_q[0];
   assign m_valid = fifo_vld_q[0];
   assign m_last  = fifo_last_q[0];

endmodule

// File: tb/tb_bram_rd_stream.sv
// Testbench for bram_rd_stream: behavioural BRAM plus a reference model that
// derives each expected beat as mem[(base + i) mod 256], last on i == length-1.
module tb_bram_rd_stream;

   logic       clk = 1'b0;
   logic       rstn;
   logic       start;
   logic [7:0] base_addr;
   logic [8:0] length;
   logic       busy;
   logic       done;
   logic [7:0] rd_addr;
   logic [7:0] bram_dout;
   logic [7:0] m_data;
   logic       m_valid;
   logic       m_ready;
   logic       m_last;

   logic [7:0] mem [256];
   logic [7:0] key;
   int         n_checks;
   int         n_pass;

   always #5 clk = ~clk;

   // Registered-read BRAM.
   always @(posedge clk) bram_dout <= mem[rd_addr];

   bram_rd_stream #(
      .DATA_WIDTH   (8),
      .ADDRESS_WIDTH(8)
   ) dut (
      .clk      (clk),
      .rstn     (rstn),
      .start    (start),
      .base_addr(base_addr),
      .length   (length),
      .busy     (busy),
      .done     (done),
      .rd_addr  (rd_addr),
      .bram_dout(bram_dout),
      .m_data   (m_data),
      .m_valid  (m_valid),
      .m_ready  (m_ready),
      .m_last   (m_last)
   );

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] want);
      n_checks++;
      if (got === want) n_pass++;
      else $display("FAIL %s: got 0x%0h want 0x%0h at %0t", tag, got, want, $time);
   endtask

   // Runs one transfer. Entered shortly after a rising edge (cycle 0), returns
   // shortly after the rising edge following completion.
   // mode 0: m_ready=1, 1: random m_ready, 2: m_ready=0 in cycles 3..9.
   task automatic run_xfer(input logic [7:0] base, input int len, input int mode, input bit noise);
      int         cyc;
      int         beats;
      int         last_hs;
      int         budget;
      int         rd_changes;
      bit         fin;
      logic [7:0] prev_rd;
      logic [7:0] a;

      start     = 1'b1;
      base_addr = base;
      length    = 9'(len);
      m_ready   = 1'b1;
      @(posedge clk); #1;
      start      = 1'b0;
      beats      = 0;
      last_hs    = -1;
      rd_changes = 0;
      fin        = 1'b0;
      prev_rd    = 8'h00;
      budget     = len * 10 + 20;

      for (cyc = 1; cyc <= budget && !fin; cyc++) begin
         case (mode)
            0:       m_ready = 1'b1;
            1:       m_ready = 1'($urandom_range(0, 1));
            default: m_ready = !(cyc >= 3 && cyc <= 9);
         endcase
         // Requests while the block is known to be busy must be ignored.
         if (noise && beats < len && $urandom_range(0, 3) == 0) begin
            start     = 1'b1;
            base_addr = 8'($urandom);
            length    = 9'($urandom_range(0, 9));
         end else begin
            start = 1'b0;
         end

         @(negedge clk);
         a = base + 8'(beats);
         if (len == 0) begin
            check("zl_valid", 32'(m_valid), 32'(0));
            check("zl_busy", 32'(busy), 32'(0));
            check("zl_done", 32'(done), 32'(cyc == 1));
            if (cyc == 4) fin = 1'b1;
         end else if (last_hs >= 0 && cyc == last_hs + 1) begin
            check("done_pulse", 32'(done), 32'(1));
            check("busy_at_done", 32'(busy), 32'(0));
            check("valid_at_done", 32'(m_valid), 32'(0));
            fin = 1'b1;
         end else begin
            check("done_early", 32'(done), 32'(0));
            check("busy", 32'(busy), 32'(1));
            if (mode == 0 && cyc >= 3) check("tput_valid", 32'(m_valid), 32'(1));
            if (mode == 2 && cyc >= 3 && cyc <= 9) check("bp_valid", 32'(m_valid), 32'(1));
            if (m_valid) begin
               check("m_data", 32'(m_data), 32'(mem[a]));
               check("m_last", 32'(m_last), 32'(beats == len - 1));
               if (mode == 0 && beats == 0) check("first_beat_cycle", 32'(cyc), 32'(3));
               if (m_ready) begin
                  beats++;
                  if (beats == len) last_hs = cyc;
               end
            end
         end
         if (mode == 2 && cyc >= 6 && cyc <= 9) begin
            if (cyc > 6 && rd_addr !== prev_rd) rd_changes++;
            prev_rd = rd_addr;
         end
         @(posedge clk); #1;
      end

      check("finished", 32'(fin), 32'(1));
      if (len > 0) begin
         check("beat_count", 32'(beats), 32'(len));
         if (mode == 0) check("done_cycle", 32'(last_hs + 1), 32'(len + 3));
         if (mode == 2) check("rd_stall", 32'(rd_changes), 32'(0));
      end
      start   = 1'b0;
      m_ready = 1'b1;
   endtask

   initial begin
      #2000000;
      $display("FAIL watchdog: simulation did not finish");
      $fatal(1, "watchdog");
   end

   initial begin
      logic [7:0] rb;
      n_checks  = 0;
      n_pass    = 0;
      rstn      = 1'b0;
      start     = 1'b0;
      base_addr = 8'h00;
      length    = 9'h000;
      m_ready   = 1'b0;

      // Odd multiplier keeps every word distinct, so a wrong address shows up as wrong data.
      key = 8'($urandom);
      for (int i = 0; i < 256; i++) mem[i] = 8'(i * 37) ^ key;
      mem[8'h10] = 8'hA0;
      mem[8'h11] = 8'hA1;
      mem[8'h12] = 8'hA2;
      mem[8'h13] = 8'hA3;

      repeat (3) @(posedge clk);
      @(negedge clk);
      check("rst_valid", 32'(m_valid), 32'(0));
      check("rst_last", 32'(m_last), 32'(0));
      check("rst_busy", 32'(busy), 32'(0));
      check("rst_done", 32'(done), 32'(0));
      check("rst_rd_addr", 32'(rd_addr), 32'(0));
      check("rst_m_data", 32'(m_data), 32'(0));

      // Start in the very first cycle after reset release.
      @(posedge clk); #1;
      rstn = 1'b1;
      run_xfer(8'h10, 4, 0, 1'b0);

      // Backpressure, wrap, zero length.
      run_xfer(8'($urandom), 8, 2, 1'b0);
      run_xfer(8'hFE, 4, 0, 1'b0);
      run_xfer(8'hFE, 4, 1, 1'b1);
      run_xfer(8'h33, 0, 0, 1'b0);

      // Reset during the second beat of a six-word stream.
      start     = 1'b1;
      base_addr = 8'h40;
      length    = 9'd6;
      m_ready   = 1'b1;
      @(posedge clk); #1;
      start = 1'b0;
      @(posedge clk); #1;
      @(posedge clk); #1;
      @(negedge clk);
      check("mid_beat1", 32'(m_data), 32'(mem[8'h40]));
      @(posedge clk); #1;
      rstn = 1'b0;
      @(negedge clk);
      check("mid_beat2", 32'(m_data), 32'(mem[8'h41]));
      @(posedge clk); #1;
      rstn = 1'b1;
      #2;
      check("mid_rst_valid", 32'(m_valid), 32'(0));
      check("mid_rst_busy", 32'(busy), 32'(0));
      check("mid_rst_done", 32'(done), 32'(0));
      run_xfer(8'h20, 2, 0, 1'b0);

      // Full depth with random backpressure and ignored requests.
      run_xfer(8'h80, 256, 1, 1'b1);

      for (int t = 0; t < 20; t++) begin
         rb = 8'($urandom);
         run_xfer(rb, $urandom_range(0, 40), $urandom_range(0, 2), 1'b1);
      end

      $display("%0d/%0d checks passed", n_pass, n_checks);
      $finish;
   end

endmodule
